// File: rtl/mem_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the data memory system.
// The master modport is the arbiter's view; slave is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              r0_re;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [DATA_W-1:0] r0_rdata;
  logic              r0_stall;

  logic              r1_re;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic [DATA_W-1:0] r1_rdata;
  logic              r1_stall;

  logic              m_re;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_stall;

  modport master (
    input  r0_re, r0_we, r0_addr, r0_wdata,
    output r0_rdata, r0_stall,
    input  r1_re, r1_we, r1_addr, r1_wdata,
    output r1_rdata, r1_stall,
    output m_re, m_we, m_addr, m_wdata,
    input  m_rdata, m_stall
  );

  modport slave (
    output r0_re, r0_we, r0_addr, r0_wdata,
    input  r0_rdata, r0_stall,
    output r1_re, r1_we, r1_addr, r1_wdata,
    input  r1_rdata, r1_stall,
    input  m_re, m_we, m_addr, m_wdata,
    output m_rdata, m_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single data memory; fixed priority to port 0 by default,
// round-robin on simultaneous requests when ARB_ROUND_ROBIN_EN is defined.
//
// state | meaning
// IDLE  | no grant, memory side driven to zero
// G0    | requester 0 owns the memory port
// G1    | requester 1 owns the memory port
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t state;
  state_t state_next;
  state_t pick;

  logic req0;
  logic req1;
  logic done;

  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  assign req0 = bus.r0_re | bus.r0_we;
  assign req1 = bus.r1_re | bus.r1_we;
  assign done = ~bus.m_stall;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer remembers the port granted most recently; ties go to the other one.
  logic last_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (state_next == G0) begin
      last_grant <= 1'b0;
    end else if (state_next == G1) begin
      last_grant <= 1'b1;
    end
  end

  assign pick = last_grant ? G0 : G1;
`else
  assign pick = G0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_next = pick;
        end else if (req0) begin
          state_next = G0;
        end else if (req1) begin
          state_next = G1;
        end
      end
      G0: begin
        // A pending peer takes over directly; otherwise the owner keeps the port.
        if (!req0) begin
          state_next = IDLE;
        end else if (done) begin
          state_next = req1 ? G1 : G0;
        end
      end
      G1: begin
        if (!req1) begin
          state_next = IDLE;
        end else if (done) begin
          state_next = req0 ? G0 : G1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign addr_sel  = (state == G1) ? bus.r1_addr  : bus.r0_addr;
  assign wdata_sel = (state == G1) ? bus.r1_wdata : bus.r0_wdata;

  always_comb begin
    bus.m_re     = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    bus.r0_rdata = '0;
    bus.r1_rdata = '0;
    case (state)
      G0: begin
        bus.m_re     = bus.r0_re & ~bus.r0_we;
        bus.m_we     = bus.r0_we;
        bus.m_addr   = addr_sel;
        bus.m_wdata  = wdata_sel;
        bus.r0_rdata = bus.m_rdata;
      end
      G1: begin
        bus.m_re     = bus.r1_re & ~bus.r1_we;
        bus.m_we     = bus.r1_we;
        bus.m_addr   = addr_sel;
        bus.m_wdata  = wdata_sel;
        bus.r1_rdata = bus.m_rdata;
      end
      default: ;
    endcase
  end

  assign bus.r0_stall = req0 & ~((state == G0) & done);
  assign bus.r1_stall = req1 & ~((state == G1) & done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, write-wins, contention,
// miss stall, withdrawal and reset during an access.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   r1_hi;

  mem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drop();
    bus.r0_re = 1'b0;
    bus.r0_we = 1'b0;
    bus.r1_re = 1'b0;
    bus.r1_we = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    r1_hi = 0;
    reset = 1'b0;
    drop();
    bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_addr = '0; bus.r1_wdata = '0;
    bus.m_rdata = '0; bus.m_stall  = 1'b0;

    // reset state
    tick();
    bus.r1_re = 1'b1;
    bus.m_rdata = 32'hCAFE_F00D;
    #1;
    chk("rst_r1_stall", 32'(bus.r1_stall), 32'd1);
    chk("rst_m_re", 32'(bus.m_re), 32'd0);
    chk("rst_m_addr", 32'(bus.m_addr), 32'd0);
    chk("rst_r1_rdata", bus.r1_rdata, 32'd0);
    bus.r1_re = 1'b0;
    tick();
    reset = 1'b1;

    // single read with minimum latency
    tick();
    bus.r0_re = 1'b1; bus.r0_addr = 12'h010; bus.m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_req_stall", 32'(bus.r0_stall), 32'd1);
    chk("rd_req_m_re", 32'(bus.m_re), 32'd0);
    tick();
    chk("rd_m_re", 32'(bus.m_re), 32'd1);
    chk("rd_m_addr", 32'(bus.m_addr), 32'h010);
    chk("rd_r0_rdata", bus.r0_rdata, 32'hDEAD_BEEF);
    chk("rd_r0_stall", 32'(bus.r0_stall), 32'd0);
    chk("rd_r1_rdata", bus.r1_rdata, 32'd0);
    tick();
    drop();
    #1;
    chk("rd_drop_m_re", 32'(bus.m_re), 32'd0);
    tick();
    chk("rd_idle_m_addr", 32'(bus.m_addr), 32'd0);

    // re and we together: write wins
    bus.r0_re = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 12'h020; bus.r0_wdata = 32'hA5A5_A5A5;
    tick();
    chk("rw_m_we", 32'(bus.m_we), 32'd1);
    chk("rw_m_re", 32'(bus.m_re), 32'd0);
    chk("rw_m_wdata", bus.m_wdata, 32'hA5A5_A5A5);
    tick();
    drop();
    tick();

    // contention straight after reset: G0 then G1 back-to-back in both modes
    pulse_reset();
    bus.r0_we = 1'b1; bus.r0_addr = 12'h030; bus.r0_wdata = 32'h1111_1111;
    bus.r1_re = 1'b1; bus.r1_addr = 12'h040;
    #1;
    chk("ct_r0_stall_idle", 32'(bus.r0_stall), 32'd1);
    chk("ct_r1_stall_idle", 32'(bus.r1_stall), 32'd1);
    tick();
    chk("ct_g0_m_we", 32'(bus.m_we), 32'd1);
    chk("ct_g0_m_addr", 32'(bus.m_addr), 32'h030);
    chk("ct_g0_r0_stall", 32'(bus.r0_stall), 32'd0);
    chk("ct_g0_r1_stall", 32'(bus.r1_stall), 32'd1);
    tick();
    bus.r0_we = 1'b0;
    #1;
    chk("ct_g1_m_re", 32'(bus.m_re), 32'd1);
    chk("ct_g1_m_addr", 32'(bus.m_addr), 32'h040);
    chk("ct_g1_r1_rdata", bus.r1_rdata, 32'hDEAD_BEEF);
    chk("ct_g1_r0_rdata", bus.r0_rdata, 32'd0);
    chk("ct_g1_r1_stall", 32'(bus.r1_stall), 32'd0);
    tick();
    drop();
    tick();

    // lone r0 grant, then contention: round-robin favours r1, fixed favours r0
    bus.r0_re = 1'b1; bus.r0_addr = 12'h034;
    tick();
    chk("solo_m_addr", 32'(bus.m_addr), 32'h034);
    tick();
    drop();
    tick();
    bus.r0_re = 1'b1; bus.r0_addr = 12'h038;
    bus.r1_re = 1'b1; bus.r1_addr = 12'h044;
    tick();
    chk("ct2_win_addr", 32'(bus.m_addr), RR ? 32'h044 : 32'h038);
    tick();
    if (RR) bus.r1_re = 1'b0;
    else    bus.r0_re = 1'b0;
    #1;
    chk("ct2_lose_addr", 32'(bus.m_addr), RR ? 32'h038 : 32'h044);
    tick();
    drop();
    tick();

    // miss stall on an r1 write queued behind r0
    pulse_reset();
    bus.r0_re = 1'b1; bus.r0_addr = 12'h050;
    bus.r1_we = 1'b1; bus.r1_addr = 12'h0FC; bus.r1_wdata = 32'h1234_5678;
    #1;
    chk("ms_idle_r0_stall", 32'(bus.r0_stall), 32'd1);
    r1_hi += int'(bus.r1_stall);
    tick();
    chk("ms_g0_m_addr", 32'(bus.m_addr), 32'h050);
    chk("ms_g0_r0_stall", 32'(bus.r0_stall), 32'd0);
    r1_hi += int'(bus.r1_stall);
    tick();
    bus.r0_addr = 12'h054;
    bus.m_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      chk("ms_stall_m_we", 32'(bus.m_we), 32'd1);
      chk("ms_stall_m_addr", 32'(bus.m_addr), 32'h0FC);
      chk("ms_stall_m_wdata", bus.m_wdata, 32'h1234_5678);
      chk("ms_stall_r0_stall", 32'(bus.r0_stall), 32'd1);
      r1_hi += int'(bus.r1_stall);
    end
    tick();
    bus.m_stall = 1'b0;
    #1;
    chk("ms_done_m_we", 32'(bus.m_we), 32'd1);
    chk("ms_done_m_addr", 32'(bus.m_addr), 32'h0FC);
    chk("ms_done_m_wdata", bus.m_wdata, 32'h1234_5678);
    chk("ms_done_r1_stall", 32'(bus.r1_stall), 32'd0);
    chk("ms_done_r0_stall", 32'(bus.r0_stall), 32'd1);
    r1_hi += int'(bus.r1_stall);
    chk("ms_r1_stall_cycles", 32'(r1_hi), 32'd5);
    tick();
    bus.r1_we = 1'b0;
    #1;
    chk("ms_handover_addr", 32'(bus.m_addr), 32'h054);
    chk("ms_handover_r0_stall", 32'(bus.r0_stall), 32'd0);
    tick();
    drop();
    tick();

    // withdrawal by r1 during a stalled grant
    bus.r1_re = 1'b1; bus.r1_addr = 12'h060; bus.m_stall = 1'b1;
    tick();
    chk("wd_m_re", 32'(bus.m_re), 32'd1);
    chk("wd_r1_stall", 32'(bus.r1_stall), 32'd1);
    tick();
    chk("wd_hold_addr", 32'(bus.m_addr), 32'h060);
    bus.r1_re = 1'b0;
    #1;
    chk("wd_drop_m_re", 32'(bus.m_re), 32'd0);
    tick();
    bus.r0_re = 1'b1;
    #1;
    chk("wd_idle_m_addr", 32'(bus.m_addr), 32'd0);
    chk("wd_idle_r0_stall", 32'(bus.r0_stall), 32'd1);
    chk("wd_idle_r1_stall", 32'(bus.r1_stall), 32'd0);
    drop();
    bus.m_stall = 1'b0;
    tick();

    // reset in the middle of a stalled r0 access
    bus.r0_re = 1'b1; bus.r0_addr = 12'h070; bus.m_stall = 1'b1;
    tick();
    chk("rm_g0_m_re", 32'(bus.m_re), 32'd1);
    reset = 1'b0;
    tick();
    chk("rm_m_re", 32'(bus.m_re), 32'd0);
    chk("rm_m_we", 32'(bus.m_we), 32'd0);
    chk("rm_r0_rdata", bus.r0_rdata, 32'd0);
    chk("rm_r0_stall", 32'(bus.r0_stall), 32'd1);
    reset = 1'b1;
    drop();
    bus.m_stall = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
